alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Buffered issue/retire stage wrapped around the 32-bit combinational `alu`. It accepts ALU commands (operands plus `op_code`) over a valid/ready handshake and queues them in a small FIFO. It drives the head command onto the ALU's `X`/`Y`/`op_code` ports and registers `Z`, `equal`, `overflow` and `zero` into an output slot with its own valid/ready handshake. It decouples the ALU from the producer and the consumer, and it counts retired results.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, ≥ 2.
- `CNT_W`, default 16: width of the retired-result counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  stage can accept a command.
- `in_x`  in  32  operand X.
- `in_y`  in  32  operand Y.
- `in_op`  in  4  ALU op_code.
- `alu_x`  out  32  to ALU `X`.
- `alu_y`  out  32  to ALU `Y`.
- `alu_op`  out  4  to ALU `op_code`.
- `alu_z`  in  32  from ALU `Z`.
- `alu_equal`  in  1  from ALU `equal`.
- `alu_overflow`  in  1  from ALU `overflow`.
- `alu_zero`  in  1  from ALU `zero`.
- `out_valid`  out  1  result slot full.
- `out_ready`  in  1  consumer takes the result.
- `out_z`  out  32  registered result.
- `out_op`  out  4  op_code that produced `out_z`.
- `out_equal`  out  1  registered flag.
- `out_overflow`  out  1  registered flag.
- `out_zero`  out  1  registered flag.
- `retired`  out  CNT_W  count of completed output handshakes.

## Operation
- **FIFO:** circular buffer with read/write pointers of log2(DEPTH) bits and an occupancy count of log2(DEPTH)+1 bits.
  - `push = in_valid & in_ready`.
  - `in_ready = (count != DEPTH)`. It does not depend on `out_ready` or on a same-cycle pop.
- **ALU drive:** combinational from the FIFO head when `count != 0`, otherwise `alu_x = 0`, `alu_y = 0`, `alu_op = 0`.
- **Issue:** `issue = (count != 0) & (~out_valid | out_ready)`. On issue:
  - pop the head;
  - load `out_z`, `out_op` and the three flags from the ALU and the head entry;
  - set `out_valid = 1`.
- **Retire:** `out_valid & out_ready` with no issue in the same cycle clears `out_valid`. Retire plus issue in the same cycle keeps `out_valid = 1` and loads the new result (back-to-back, one result per cycle).
- **Output hold:** while `out_valid & ~out_ready`, the output registers hold their values and must not change.
- **Counts:**
  - Simultaneous push and pop: `count` unchanged; both pointers advance.
  - Pointers wrap modulo DEPTH.
- **Retired counter:** `retired` increments by 1 on each `out_valid & out_ready`; it wraps from all-ones to 0.
- **Flags:** pass through raw. `overflow` is meaningful only for add/sub op_codes, and this stage does not mask it.
- **Reset:** applies at the next edge with `rst = 1` and overrides push, issue and retire. All of the following are cleared:
  - FIFO emptied, pointers and count = 0;
  - `out_valid = 0`, `out_z = 0`, `out_op = 0`, all flags = 0, `retired = 0`;
  - in-flight commands are discarded, not retired.

## Timing
- **In reset:** `in_ready = 0` while `rst` is high. After reset, `in_ready = 1` and `out_valid = 0`.
- **Latency:** a command pushed at edge N issues at edge N+1 at the earliest, giving `out_valid = 1` after N+1 (2 cycles accept-to-result). Because there is no bypass, an empty FIFO never issues in the push cycle.
- **Throughput:** 1 command per cycle sustained with `out_ready` held high.
- **Full FIFO:** `in_ready = 0` for the cycle. A pop in that cycle frees an entry, visible as `in_ready = 1` on the next cycle.
- **Stall:** with `out_ready = 0`, one result is held and DEPTH commands buffer, then `in_ready` falls. The stage holds DEPTH+1 commands in total.
- **ALU path:** combinational from head, through the ALU, into the output registers, all in a single cycle.

## Test plan
- **Reset:** hold `rst` 2 cycles with `in_valid = 1` -> `in_ready = 0`, `out_valid = 0`, `out_z = 0`, `retired = 0`. After release, `in_ready = 1` and no result appears.
- **Single op:** push op 0 (AND), X=0xF0F0F0F0, Y=0xFF00FF00, with `out_ready = 1` -> `out_valid` rises 2 cycles after the push with `out_z = 0xF000F000`, `out_op = 0`. `retired` reads 1 one cycle later.
- **Streaming:** push OR, XOR, NOR back-to-back on X=0x0000FFFF, Y=0x00FF00FF -> consecutive results 0x00FFFFFF, 0x00FFFF00, 0xFF000000 in order, one per cycle.
- **Equal operands:** XOR with X = Y = 0x12345678 -> `out_z = 0`, `out_equal = 1`, `out_zero` as driven by the ALU.
- **Backpressure:** `out_ready = 0`, push 6 commands (DEPTH = 4) -> exactly 5 accepted and `in_ready = 0` with count = 4. Raising `out_ready` drains all 5 in FIFO order over 5 cycles with `out_z` stable during the stall.
- **Reset mid-operation:** reset with 3 queued commands and `out_valid = 1` -> all dropped, `out_valid = 0`, `retired = 0`. A subsequent push returns its correct result only.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Buffered issue/retire stage around a 32-bit combinational ALU.
// Commands (X, Y, op_code) enter over a valid/ready handshake and are queued
// in a DEPTH-entry circular FIFO. The head entry drives the ALU inputs
// combinationally, and the ALU result plus flags are captured into a
// registered output slot that has its own valid/ready handshake. A counter
// tracks every completed output handshake.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     command handshake; in_x, in_y, in_op command fields
//   alu_x/alu_y/alu_op    head command driven to the ALU (zero when empty)
//   alu_z/alu_equal/alu_overflow/alu_zero   ALU result and flags
//   out_valid/out_ready   result handshake; out_z, out_op, out_* flags
//   retired               count of completed output handshakes (wraps)
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [3:0]       in_op,
    output logic [31:0]      alu_x,
    output logic [31:0]      alu_y,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_z,
    input  logic             alu_equal,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_z,
    output logic [3:0]       out_op,
    output logic             out_equal,
    output logic             out_overflow,
    output logic             out_zero,
    output logic [CNT_W-1:0] retired
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem_x  [DEPTH];
    logic [31:0]   mem_y  [DEPTH];
    logic [3:0]    mem_op [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic fifo_empty;
    logic push;
    logic issue;
    logic retire;

    // Handshake decode; in_ready is forced low while reset is asserted and
    // never looks at a same-cycle pop, so a full FIFO always stalls one cycle.
    always_comb begin
        fifo_empty = (count == {(AW + 1){1'b0}});
        in_ready   = ~rst & (count != FULL_COUNT);
        push       = in_valid & in_ready;
        issue      = ~fifo_empty & (~out_valid | out_ready);
        retire     = out_valid & out_ready;
    end

    // Head of the FIFO drives the ALU; idle inputs are zero when empty.
    always_comb begin
        alu_x  = 32'h0000_0000;
        alu_y  = 32'h0000_0000;
        alu_op = 4'h0;
        if (!fifo_empty) begin
            alu_x  = mem_x[rd_ptr];
            alu_y  = mem_y[rd_ptr];
            alu_op = mem_op[rd_ptr];
        end else begin
            alu_x  = 32'h0000_0000;
            alu_y  = 32'h0000_0000;
            alu_op = 4'h0;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr]  <= in_x;
            mem_y[wr_ptr]  <= in_y;
            mem_op[wr_ptr] <= in_op;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= {AW{1'b0}};
            wr_ptr <= {AW{1'b0}};
            count  <= {(AW + 1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Output slot: loads on issue (including back-to-back with a retire),
    // empties on a retire without a refill, otherwise holds steady.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_z        <= 32'h0000_0000;
            out_op       <= 4'h0;
            out_equal    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
        end else if (issue) begin
            out_valid    <= 1'b1;
            out_z        <= alu_z;
            out_op       <= mem_op[rd_ptr];
            out_equal    <= alu_equal;
            out_overflow <= alu_overflow;
            out_zero     <= alu_zero;
        end else if (retire) begin
            out_valid    <= 1'b0;
        end
    end

    // Retired-result counter, wraps from all-ones to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= {CNT_W{1'b0}};
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
// Directed bench for alu_issue_stage. A small behavioural ALU closes the
// loop (0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB); expected results are
// hand-computed constants.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [3:0]  in_op;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [3:0]  alu_op;
    logic [31:0] alu_z;
    logic        alu_equal;
    logic        alu_overflow;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [3:0]  out_op;
    logic        out_equal;
    logic        out_overflow;
    logic        out_zero;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;
    int accepted;

    always #5 clk = ~clk;

    alu_issue_stage #(.DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_op        (in_op),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_op       (alu_op),
        .alu_z        (alu_z),
        .alu_equal    (alu_equal),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_op       (out_op),
        .out_equal    (out_equal),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .retired      (retired)
    );

    // Behavioural combinational ALU.
    always_comb begin
        alu_z        = 32'h0000_0000;
        alu_overflow = 1'b0;
        case (alu_op)
            4'd0: alu_z = alu_x & alu_y;
            4'd1: alu_z = alu_x | alu_y;
            4'd2: alu_z = alu_x ^ alu_y;
            4'd3: alu_z = ~(alu_x | alu_y);
            4'd4: begin
                alu_z        = alu_x + alu_y;
                alu_overflow = (alu_x[31] == alu_y[31]) && (alu_z[31] != alu_x[31]);
            end
            4'd5: begin
                alu_z        = alu_x - alu_y;
                alu_overflow = (alu_x[31] != alu_y[31]) && (alu_z[31] != alu_x[31]);
            end
            default: alu_z = 32'h0000_0000;
        endcase
        alu_equal = (alu_x == alu_y);
        alu_zero  = (alu_z == 32'h0000_0000);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_op    = op;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_x      = 32'hDEAD_BEEF;
        in_y      = 32'h1234_5678;
        in_op     = 4'd4;
        out_ready = 1'b1;

        // Reset held two cycles with a command offered.
        step();
        step();
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_z",     out_z,     32'h0);
        check("rst_retired",   retired,   16'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        step();
        check("post_rst_no_result", out_valid, 1'b0);

        // Single AND op: result two edges after the push edge.
        set_cmd(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0);
        step();
        in_valid = 1'b0;
        check("single_no_bypass", out_valid, 1'b0);
        step();
        check("single_valid", out_valid, 1'b1);
        check("single_z",     out_z,     32'hF000_F000);
        check("single_op",    out_op,    4'd0);
        step();
        check("single_retired", retired,   16'd1);
        check("single_drained", out_valid, 1'b0);

        // Streaming OR, XOR, NOR back-to-back.
        set_cmd(32'h0000_FFFF, 32'h00FF_00FF, 4'd1);
        step();
        set_cmd(32'h0000_FFFF, 32'h00FF_00FF, 4'd2);
        step();
        check("stream_or_z",  out_z,  32'h00FF_FFFF);
        check("stream_or_op", out_op, 4'd1);
        set_cmd(32'h0000_FFFF, 32'h00FF_00FF, 4'd3);
        step();
        in_valid = 1'b0;
        check("stream_xor_z", out_z, 32'h00FF_FF00);
        check("stream_xor_v", out_valid, 1'b1);
        step();
        check("stream_nor_z",  out_z,  32'hFF00_0000);
        check("stream_nor_op", out_op, 4'd3);
        step();
        check("stream_done",    out_valid, 1'b0);
        check("stream_retired", retired,   16'd4);

        // Equal operands through XOR.
        set_cmd(32'h1234_5678, 32'h1234_5678, 4'd2);
        step();
        in_valid = 1'b0;
        step();
        check("eq_z",     out_z,     32'h0);
        check("eq_equal", out_equal, 1'b1);
        check("eq_zero",  out_zero,  1'b1);
        step();

        // Signed overflow on ADD passes through unmasked.
        set_cmd(32'h7FFF_FFFF, 32'h0000_0001, 4'd4);
        step();
        in_valid = 1'b0;
        step();
        check("ovf_z",     out_z,        32'h8000_0000);
        check("ovf_flag",  out_overflow, 1'b1);
        check("ovf_equal", out_equal,    1'b0);
        step();
        check("ovf_retired", retired, 16'd6);

        // Backpressure: six offers, five accepted (one held + four queued).
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            set_cmd(32'h0000_0100, 32'(i), 4'd4);
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(accepted), 64'd5);
        check("bp_in_ready", in_ready,  1'b0);
        check("bp_valid",    out_valid, 1'b1);
        check("bp_head_z",   out_z,     32'h100);
        step();
        step();
        check("bp_hold_z",  out_z,   32'h100);
        check("bp_hold_op", out_op,  4'd4);
        check("bp_hold_rt", retired, 16'd6);
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            check("bp_drain_z", out_z, 32'h100 + 32'(i));
            if (i == 1) check("bp_ready_back", in_ready, 1'b1);
        end
        step();
        check("bp_empty",   out_valid, 1'b0);
        check("bp_retired", retired,   16'd11);

        // Reset with three queued commands and a held result.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(32'hFFFF_FFFF, 32'(i + 1), 4'd0);
            step();
        end
        in_valid = 1'b0;
        check("mid_pre_valid", out_valid, 1'b1);
        check("mid_pre_z",     out_z,     32'h1);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        check("mid_valid",    out_valid, 1'b0);
        check("mid_retired",  retired,   16'd0);
        check("mid_z",        out_z,     32'h0);
        check("mid_in_ready", in_ready,  1'b0);
        rst = 1'b0;
        step();
        check("mid_no_stale", out_valid, 1'b0);
        set_cmd(32'h0000_0005, 32'h0000_0007, 4'd5);
        step();
        in_valid = 1'b0;
        step();
        check("mid_new_z",   out_z,        32'hFFFF_FFFE);
        check("mid_new_op",  out_op,       4'd5);
        check("mid_new_ovf", out_overflow, 1'b0);
        step();
        check("mid_new_empty",   out_valid, 1'b0);
        check("mid_new_retired", retired,   16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
